// File: rtl/serial_adder_controller.sv
// serial_adder_controller: adds two WIDTH-bit operands one bit per clock,
// LSB first, through a single full adder and a carry register. Operands
// arrive through a valid/ready handshake; the sum and carry-out leave through
// a second valid/ready handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' port that turns the
// operation into A - B (A + ~B + 1); carry_out=1 then means "no borrow".
module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             b_bit;
  logic             s_bit;
  logic             carry_d;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q;
  assign b_bit = b_sr[0] ^ sub_q;
`else
  assign b_bit = b_sr[0];
`endif

  assign s_bit    = a_sr[0] ^ b_bit ^ carry;
  assign carry_d  = (a_sr[0] & b_bit) | (carry & (a_sr[0] ^ b_bit));
  assign last_bit = (cnt == LAST_BIT);

  // After the final shift the sum shift register holds the complete result,
  // and it is left untouched in DONE and IDLE, so it serves as the output.
  assign sum = sum_sr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; handshake outputs depend only on the current state
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, shift one bit per clock while running
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q <= sub;
            carry <= sub;
`else
            carry <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          carry  <= carry_d;
          if (last_bit) begin
            carry_out <= carry_d;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
// tb_serial_adder_controller: scoreboard bench for serial_adder_controller.
// Expected results are pushed when an operand pair is accepted and popped by a
// monitor whenever the DUT hands a result over (out_valid & out_ready).
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
module tb_serial_adder_controller;

  localparam int W = 8;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;

  logic [W:0]   exp_q[$];
  int           asserts;
  int           failures;
  bit           done;
  bit           rand_done;
  int           cyc;

  serial_adder_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on WIDTH+1 bits; bit W is carry_out
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input bit sv);
    logic [W:0] r;
    if (sv) begin
      r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    end else begin
      r = {1'b0, av} + {1'b0, bv};
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    asserts++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called and returns at 1 time unit after a posedge
  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_sum", sum, 0);
    check_output("reset_carry_out", carry_out, 0);
    rst = 1'b0;
  endtask

  // Present operands once the DUT is ready; push the expected result on accept
  task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input bit sv);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      check_output("accept_timeout_in_ready", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    sub      = sv & SUB_EN;
    @(posedge clk);
    exp_q.push_back(model(av, bv, sv & SUB_EN));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    check_output("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < W + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [W:0] e;
    int         n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    asserts   = 0;
    failures  = 0;
    done      = 1'b0;
    rand_done = 1'b0;
    cyc       = 0;

    fork
      // Monitor: compares each handed-over result with the scoreboard head
      begin
        while (!done) begin
          @(negedge clk);
          cyc++;
          if (cyc > 60000) begin
            $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
            $fatal(1, "[TB] watchdog expired");
          end
          if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              asserts++;
              failures++;
              $display("[TB] FAIL unexpected_result: got sum 0x%0h carry %0b, expected no result",
                       sum, carry_out);
            end else begin
              e = exp_q.pop_front();
              check_output("sum", sum, e[W-1:0]);
              check_output("carry_out", carry_out, e[W]);
            end
          end
        end
      end

      // Stimulus
      begin
        reset_dut();

        $display("[TB] basic add and latency");
        apply_stimulus(8'd3, 8'd5, 1'b0);
        wait_out_valid(n);
        check_output("latency_cycles", n, W);
        wait_drain();
        apply_stimulus(8'd200, 8'd100, 1'b0);
        apply_stimulus(8'd255, 8'd1, 1'b0);
        wait_drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        e = model(8'h5A, 8'h33, 1'b0);
        apply_stimulus(8'h5A, 8'h33, 1'b0);
        wait_out_valid(n);
        for (int i = 0; i < 5; i++) begin
          in_valid = (i == 1 || i == 3);
          a        = 8'hFF;
          b        = 8'hFF;
          @(posedge clk);
          #1;
          check_output("stall_out_valid", out_valid, 1);
          check_output("stall_in_ready", in_ready, 0);
          check_output("stall_sum", sum, e[W-1:0]);
          check_output("stall_carry_out", carry_out, e[W]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("pop_in_ready", in_ready, 1);
        check_output("pop_out_valid", out_valid, 0);
        apply_stimulus(8'd1, 8'd1, 1'b0);
        wait_drain();

        $display("[TB] in_valid held during run");
        apply_stimulus(8'h3C, 8'h4B, 1'b0);
        in_valid = 1'b1;
        a        = 8'h11;
        b        = 8'h22;
        n = 0;
        while (!in_ready && n < 3 * W) begin
          @(posedge clk);
          #1;
          n++;
        end
        check_output("held_valid_cycles_to_ready", n, W + 1);
        @(posedge clk);
        exp_q.push_back(model(8'h11, 8'h22, 1'b0));
        #1;
        in_valid = 1'b0;
        wait_drain();

        $display("[TB] reset mid-run");
        apply_stimulus(8'h77, 8'h11, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_output("midreset_in_ready", in_ready, 1);
        check_output("midreset_out_valid", out_valid, 0);
        check_output("midreset_sum", sum, 0);
        check_output("midreset_carry_out", carry_out, 0);
        rst = 1'b0;
        apply_stimulus(8'd10, 8'd20, 1'b0);
        wait_drain();

        if (SUB_EN) begin
          $display("[TB] subtraction");
          apply_stimulus(8'd5, 8'd7, 1'b1);
          apply_stimulus(8'd7, 8'd5, 1'b1);
          wait_drain();
        end

        $display("[TB] randomized traffic");
        fork
          begin
            for (int i = 0; i < 25; i++) begin
              logic [W-1:0] ra;
              logic [W-1:0] rb;
              ra = W'($urandom);
              rb = (i % 5 == 0) ? {W{1'b1}} : W'($urandom);
              apply_stimulus(ra, rb, 1'($urandom_range(0, 1)));
              repeat ($urandom_range(0, 3)) @(posedge clk);
              #1;
            end
            wait_drain();
            rand_done = 1'b1;
          end
          begin
            while (!rand_done) begin
              @(posedge clk);
              #1;
              out_ready = 1'($urandom_range(0, 1));
            end
          end
        join
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        done = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Sequencing controller that wraps a 1-bit full-adder datapath and its carry register to add two WIDTH-bit operands serially, LSB first, one bit per clock. It accepts parallel operands through a valid/ready handshake. It shifts the operands through the adder and assembles the sum in a shift register. It presents the parallel sum and carry-out through a second valid/ready handshake. It sits between a parallel producer and a parallel consumer that share one cheap serial adder.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A, sampled on the accept edge.
- b  input  WIDTH  operand B, sampled on the accept edge.
- sub  input  1  only present with SERIAL_ADDER_SUB_EN; sampled on the accept edge; 1 selects A−B.
- out_valid  output  1  sum and carry_out hold a completed result.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result, mod 2^WIDTH.
- carry_out  output  1  final carry out of bit WIDTH−1.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high at a posedge:
    - load a_sr←a and b_sr←b;
    - clear carry to 0, or set it to sub under the macro;
    - clear bit counter to 0;
    - go to RUN.
- RUN:
  - in_ready=0, out_valid=0. in_valid is ignored.
  - The full-adder equations use only ^, &, |, ~:
    - s = a_sr[0] ^ b' ^ carry;
    - carry_d = (a_sr[0] & b') | (carry & (a_sr[0] ^ b'));
    - b' = b_sr[0], or b_sr[0] ^ sub under the macro.
  - At each posedge:
    - sum_sr ← {s, sum_sr[WIDTH−1:1]};
    - a_sr and b_sr shift right by 1;
    - carry ← carry_d;
    - counter increments.
  - On the posedge with counter==WIDTH−1:
    - go to DONE;
    - sum ← final sum_sr value;
    - carry_out ← carry_d.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and carry_out are held stable.
  - When out_ready is high at a posedge, go to IDLE.
- sum and carry_out keep the last result after the pop and are meaningful only while out_valid=1.
- Counter width is $clog2(WIDTH); it never wraps past WIDTH−1 within one operation.
- Reset, any state, including mid-RUN:
  - next state is IDLE;
  - counter, carry, shift registers, sum and carry_out are all 0;
  - the in-flight operation is discarded and no partial result is presented.
- Reset outputs: in_ready=1, out_valid=0, sum=0, carry_out=0.

## Timing
- Accept edge E0 is the posedge with in_valid & in_ready.
- Bits are processed on edges E1..E_WIDTH.
- out_valid rises after E_WIDTH. Latency from accept to result is WIDTH cycles.
- The pop edge is a posedge in DONE with out_ready=1. in_ready rises after it.
- A new accept can occur no earlier than the edge following the pop. Minimum initiation interval is WIDTH+2 cycles.
- in_ready and out_valid are pure functions of state, with no combinational path from in_valid or out_ready.
- out_ready held low stalls indefinitely in DONE with no data change.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists;
  - sub=1 computes A + ~B + 1;
  - carry_out=1 means no borrow (A ≥ B unsigned).
- SERIAL_ADDER_SUB_EN undefined:
  - the sub port is absent;
  - carry is initialised to 0;
  - behaviour is addition only.

## Test plan
- WIDTH=8, a=3, b=5 → out_valid after exactly 8 cycles from accept, sum=8, carry_out=0.
- a=200, b=100 → sum=44 (0x2C), carry_out=1. Also a=255, b=1 → sum=0, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum, carry_out and out_valid stable; in_ready stays 0; in_valid pulses are ignored. Then out_ready=1 → IDLE next cycle, then a back-to-back op with a=1, b=1 → sum=2.
- in_valid held high with new operands throughout RUN → those operands are not accepted; the first result is uncorrupted; the second op is accepted only in IDLE.
- Assert rst for 1 cycle when counter=4 → next cycle in_ready=1, out_valid=0, sum=0. A subsequent a=10, b=20 → sum=30.
- With SERIAL_ADDER_SUB_EN:
  - a=5, b=7, sub=1 → sum=0xFE, carry_out=0;
  - a=7, b=5, sub=1 → sum=2, carry_out=1.
